// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a power-of-2 circular FIFO feeds a start/data/parity/stop
// serialiser whose line output is registered.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 7372800,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              Clk,
    input  logic                              Rstn,
    input  logic [DATA_BITS-1:0]              Tx_data,
    input  logic                              Tx_valid,
    output logic                              Tx_ready,
    output logic                              Uart_tx,
    output logic                              Busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic              PAR_INV    = (PARITY_ODD != 0);

    if ((CLK_FREQ % BAUD) != 0 || (CLK_FREQ / BAUD) < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUD must be an exact integer >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   wr_en;
    logic                   pop;
    logic                   baud_wrap;
    logic                   fifo_nempty;
    logic [DATA_BITS-1:0]   head;

    assign Tx_ready    = (count_q != FULL_COUNT);
    assign wr_en       = Tx_valid && Tx_ready;
    assign fifo_nempty = (count_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign baud_wrap   = (baud_q == BAUD_LAST);

    assign Uart_tx    = tx_q;
    assign Busy       = (state_q != S_IDLE) || fifo_nempty;
    assign Fifo_count = count_q;

    // Serialiser next-state; tx_d is always the value the line carries after this edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Queued byte: next start bit follows the last stop bit with no gap.
                        if (fifo_nempty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            shift_d = head;
            par_d   = (^head) ^ PAR_INV;
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Datapath storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        if (wr_en) begin
            mem_q[wr_ptr_q] <= Tx_data;
        end
    end

endmodule
